// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer and per-word bit order.
// Latency: a word accepted into an empty buffer while idle drives its first bit one cycle after acceptance.
// Backpressure: data_ready = !buf_full; back-to-back words stream with no idle bit between them.
module piso_serializer #(
    parameter int   WORD_LENGTH  = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] data_in,
    input  logic                   lsb_first,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   serial_out,
    output logic                   bit_strobe,
    output logic                   busy,
    output logic                   word_done
);

    localparam int BW = $clog2(WORD_LENGTH);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LENGTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q,    state_d;
    logic                   buf_full_q, buf_full_d;
    logic [WORD_LENGTH-1:0] buf_dat_q,  buf_dat_d;
    logic                   buf_lsb_q,  buf_lsb_d;
    logic [WORD_LENGTH-1:0] sr_q,       sr_d;
    logic                   lsb_q,      lsb_d;
    logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [DW-1:0]          div_cnt_q,  div_cnt_d;

    logic in_shift;
    logic div_wrap;
    logic last_cycle;

    assign in_shift   = (state_q == SHIFT);
    assign div_wrap   = (div_cnt_q == DIV_LAST);
    assign last_cycle = in_shift && div_wrap && (bit_cnt_q == BIT_LAST);

    // Output decodes, all from registered state only (no input-to-output paths).
    always_comb begin
        data_ready = !buf_full_q;
        busy       = in_shift || buf_full_q;
        bit_strobe = in_shift && (div_cnt_q == '0);
        word_done  = last_cycle;
        serial_out = IDLE_LEVEL;
        if (in_shift) begin
            serial_out = lsb_q ? sr_q[0] : sr_q[WORD_LENGTH-1];
        end
    end

    // Next state: buffer drain into the shift register, bit timing, and input capture.
    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_dat_d  = buf_dat_q;
        buf_lsb_d  = buf_lsb_q;
        sr_d       = sr_q;
        lsb_d      = lsb_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;

        if ((!in_shift && buf_full_q) || (last_cycle && buf_full_q)) begin
            // Start a fresh word; mode is latched here so it never changes mid-word.
            state_d    = SHIFT;
            sr_d       = buf_dat_q;
            lsb_d      = buf_lsb_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            div_cnt_d  = '0;
        end else if (last_cycle) begin
            state_d   = IDLE;
            sr_d      = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else if (in_shift) begin
            if (div_wrap) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 1'b1;
                sr_d      = lsb_q ? (sr_q >> 1) : (sr_q << 1);
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        // Accept only into an empty buffer, so it can never coincide with a drain.
        if (data_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_dat_d  = data_in;
            buf_lsb_d  = lsb_first;
        end
    end

    // State registers; reset aborts any word in flight and empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_dat_q  <= '0;
            buf_lsb_q  <= 1'b0;
            sr_q       <= '0;
            lsb_q      <= 1'b0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_dat_q  <= buf_dat_d;
            buf_lsb_q  <= buf_lsb_d;
            sr_q       <= sr_d;
            lsb_q      <= lsb_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (1 and 4 clocks per bit) sharing inputs.
// Table vectors, hand-written multi-cycle sequences, then random traffic against a timeline model.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lsb_first = 1'b0;
    logic       data_valid = 1'b0;

    logic rdy1, ser1, stb1, busy1, done1;
    logic rdy4, ser4, stb4, busy4, done4;

    always #5 clk = ~clk;

    piso_serializer #(.WORD_LENGTH(8), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst_n), .data_in(data_in), .lsb_first(lsb_first),
        .data_valid(data_valid), .data_ready(rdy1), .serial_out(ser1),
        .bit_strobe(stb1), .busy(busy1), .word_done(done1)
    );

    piso_serializer #(.WORD_LENGTH(8), .CLKS_PER_BIT(4), .IDLE_LEVEL(1'b0)) u_dut4 (
        .clk(clk), .rst(rst_n), .data_in(data_in), .lsb_first(lsb_first),
        .data_valid(data_valid), .data_ready(rdy4), .serial_out(ser4),
        .bit_strobe(stb4), .busy(busy4), .word_done(done4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // ---------------- reference model: word timeline ----------------
    // A word accepted on edge k starts at max(k+1, end of previous word) and
    // occupies 8*cpb cycles; the buffer is full from acceptance until start.
    bit         model_on = 1'b0;
    bit         m_cur_v[2], m_pend_v[2], m_cur_lsb[2], m_pend_lsb[2];
    logic [7:0] m_cur_dat[2], m_pend_dat[2];
    int         m_start[2], m_pacc[2], m_t[2];
    bit         m_acc;

    function automatic int cpb_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!model_on) begin
                m_cur_v[d] = 1'b0; m_pend_v[d] = 1'b0; m_t[d] = 0;
                m_start[d] = 0; m_pacc[d] = 0;
            end else begin
                m_acc = data_valid && !m_pend_v[d];
                m_t[d]++;
                if (m_cur_v[d] && m_t[d] == m_start[d] + 8 * cpb_of(d)) m_cur_v[d] = 1'b0;
                if (m_pend_v[d] && !m_cur_v[d] && m_t[d] > m_pacc[d]) begin
                    m_cur_v[d] = 1'b1; m_cur_dat[d] = m_pend_dat[d];
                    m_cur_lsb[d] = m_pend_lsb[d]; m_start[d] = m_t[d];
                    m_pend_v[d] = 1'b0;
                end
                if (m_acc) begin
                    m_pend_v[d] = 1'b1; m_pend_dat[d] = data_in;
                    m_pend_lsb[d] = lsb_first; m_pacc[d] = m_t[d];
                end
            end
        end
    end

    // {serial_out, data_ready, busy, bit_strobe, word_done}
    function automatic logic [4:0] model_out(input int d);
        logic s, st, dn;
        int   p, i, c;
        c = cpb_of(d); s = 1'b0; st = 1'b0; dn = 1'b0;
        if (m_cur_v[d]) begin
            p  = m_t[d] - m_start[d];
            i  = p / c;
            s  = m_cur_lsb[d] ? m_cur_dat[d][i] : m_cur_dat[d][7-i];
            st = ((p % c) == 0);
            dn = (p == 8 * c - 1);
        end
        return {s, !m_pend_v[d], m_cur_v[d] || m_pend_v[d], st, dn};
    endfunction

    function automatic logic [4:0] dut_out(input int d);
        return (d == 0) ? {ser1, rdy1, busy1, stb1, done1} : {ser4, rdy4, busy4, stb4, done4};
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- table vectors (1 clock per bit) ----------------
    typedef struct {
        logic [7:0] dat;
        logic       lsb;
        logic [7:0] exp_seq;   // serial bits in time order, first bit in [7]
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  seq;
        logic [23:0] seq24, dmask24;
        logic [31:0] sp, st, dn;
        int nstb, ndone, dpos, nlow, resid;

        vecs[0] = '{dat: 8'h1E, lsb: 1'b1, exp_seq: 8'h78};
        vecs[1] = '{dat: 8'h1E, lsb: 1'b0, exp_seq: 8'h1E};
        vecs[2] = '{dat: 8'hC4, lsb: 1'b1, exp_seq: 8'h23};
        vecs[3] = '{dat: 8'hC4, lsb: 1'b0, exp_seq: 8'hC4};
        vecs[4] = '{dat: 8'h80, lsb: 1'b1, exp_seq: 8'h01};
        vecs[5] = '{dat: 8'hFF, lsb: 1'b0, exp_seq: 8'hFF};

        // Reset values while rst is held low.
        repeat (3) @(negedge clk);
        chk("reset_out_dut1", {27'd0, dut_out(0)}, 32'h08);
        chk("reset_out_dut4", {27'd0, dut_out(1)}, 32'h08);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            @(negedge clk); data_in = vecs[v].dat; lsb_first = vecs[v].lsb; data_valid = 1'b1;
            @(negedge clk); data_valid = 1'b0;
            seq = '0; nstb = 0; ndone = 0; dpos = -1;
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                seq = {seq[6:0], ser1};
                nstb += int'(stb1);
                if (done1) begin ndone++; dpos = j; end
            end
            chk($sformatf("tbl%0d_bits", v), {24'd0, seq}, {24'd0, vecs[v].exp_seq});
            chk($sformatf("tbl%0d_strobes", v), nstb, 8);
            chk($sformatf("tbl%0d_done", v), {ndone[15:0], dpos[15:0]}, {16'd1, 16'd8});
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", v), {29'd0, busy1, ser1, rdy1}, 32'h1);
        end

        // Back-to-back: 1E LSB, F0 MSB two cycles later, 3C LSB held until taken.
        do_reset();
        @(negedge clk); data_in = 8'h1E; lsb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk); data_valid = 1'b0;
        seq24 = '0; dmask24 = '0; nstb = 0; nlow = 0;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            seq24   = {seq24[22:0], ser1};
            dmask24 = {dmask24[22:0], done1};
            nstb   += int'(stb1);
            if (j >= 3 && j <= 8 && !rdy1) nlow++;
            if (j == 9)  chk("b2b_ready_after_reload", {31'd0, rdy1}, 32'd1);
            if (j == 10) chk("b2b_third_taken", {30'd0, rdy1, busy1}, 32'h1);
            if (j == 1) begin data_in = 8'hF0; lsb_first = 1'b0; data_valid = 1'b1; end
            if (j == 2) begin data_in = 8'h3C; lsb_first = 1'b1; data_valid = 1'b1; end
            if (j == 10) data_valid = 1'b0;
        end
        chk("b2b_ready_low", nlow, 6);
        chk("b2b_bits", {8'd0, seq24}, 32'h0078F03C);
        chk("b2b_done_mask", {8'd0, dmask24}, 32'h00010101);
        chk("b2b_strobes", nstb, 24);
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy1, ser1}, 32'd0);

        // Four clocks per bit: 8'h01 LSB first.
        do_reset();
        @(negedge clk); data_in = 8'h01; lsb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk); data_valid = 1'b0;
        sp = '0; st = '0; dn = '0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            sp = {sp[30:0], ser4};
            st = {st[30:0], stb4};
            dn = {dn[30:0], done4};
        end
        chk("cpb4_serial", sp, 32'hF000_0000);
        chk("cpb4_strobe", st, 32'h8888_8888);
        chk("cpb4_done", dn, 32'h0000_0001);
        @(negedge clk);
        chk("cpb4_idle", {31'd0, busy4}, 32'd0);

        // Reset mid-word with a second word sitting in the buffer.
        do_reset();
        @(negedge clk); data_in = 8'hFF; lsb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk); data_in = 8'hAA;
        @(negedge clk);
        @(negedge clk); data_valid = 1'b0;
        chk("midrst_buf_full", {30'd0, rdy1, busy1}, 32'h1);
        @(negedge clk);
        chk("midrst_pre_serial", {31'd0, ser1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_now_dut1", {27'd0, dut_out(0)}, 32'h08);
        chk("midrst_now_dut4", {27'd0, dut_out(1)}, 32'h08);
        @(negedge clk); rst_n = 1'b1;
        resid = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (dut_out(0) != 5'h08) resid++;
            if (dut_out(1) != 5'h08) resid++;
        end
        chk("midrst_residual", resid, 0);

        // Random traffic against the timeline model, both instances.
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk($sformatf("rnd_dut%0d_c%0d", cpb_of(d), c), {27'd0, dut_out(d)}, {27'd0, model_out(d)});
            data_in    = 8'($urandom);
            lsb_first  = 1'($urandom);
            data_valid = ((c / 150) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
        end
        data_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer. Successor to the fixed LSB-first shift register: selectable bit order per word, programmable bit period, valid/ready input handshake, and a one-word holding buffer so consecutive words stream with no idle gap. It feeds serial links such as the UART TX and SPI-style outputs in the P-series designs.

Parameters:
WORD_LENGTH, 8, bits per word; must be >= 2
CLKS_PER_BIT, 1, clock cycles each bit is held on serial_out; must be >= 1
IDLE_LEVEL, 1'b0, value driven on serial_out while no word is being shifted

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
data_in  input  WORD_LENGTH  parallel word to send
lsb_first  input  1  bit order for the word; sampled together with data_in; 1 = LSB first, 0 = MSB first
data_valid  input  1  data_in/lsb_first valid
data_ready  output  1  block can accept a word
serial_out  output  1  serial data
bit_strobe  output  1  high on the first cycle of every bit
busy  output  1  high while in SHIFT or while the buffer is full
word_done  output  1  high on the last cycle of the last bit of a word

Behaviour:
- Reset: one clock (clk); asynchronous active-low reset (rst). On rst = 0, all state clears immediately:
  - FSM = IDLE, buffer empty, shift register and counters = 0.
  - Outputs: serial_out = IDLE_LEVEL, data_ready = 1, busy = 0, bit_strobe = 0, word_done = 0.
  - Reset mid-word aborts the word and discards the buffered word. Nothing resumes after reset release.
- Handshake:
  - A word is accepted on a rising edge when data_valid && data_ready. data_in and lsb_first are written to the buffer and buf_full is set.
  - data_ready = !buf_full, decoded combinationally from the registered flag.
  - No accept occurs in the same cycle the buffer drains.
  - data_valid while data_ready = 0 is ignored, and the input is not captured.
- FSM states are IDLE and SHIFT.
  - IDLE, buffer full: on the next edge, load the shift register and mode from the buffer, clear buf_full, set bit_cnt = 0 and div_cnt = 0, and go to SHIFT.
  - SHIFT: div_cnt increments each cycle and wraps at CLKS_PER_BIT-1. On wrap, the shift register shifts and bit_cnt increments.
    - LSB mode: serial_out = sr[0], shift right, zero fill.
    - MSB mode: serial_out = sr[WORD_LENGTH-1], shift left, zero fill.
  - Last cycle of a word is bit_cnt == WORD_LENGTH-1 && div_cnt == CLKS_PER_BIT-1. On that edge:
    - if buf_full: reload directly from the buffer and stay in SHIFT (zero-gap back-to-back);
    - else: go to IDLE.
- Latency: for a word accepted on edge k into an empty buffer in IDLE, the first bit appears after edge k+1.
- Output decodes (combinational from registered state):
  - bit_strobe = SHIFT && div_cnt == 0.
  - word_done = SHIFT && last cycle.
  - serial_out = IDLE_LEVEL in IDLE.
- Counter widths: bit_cnt is $clog2(WORD_LENGTH) bits; div_cnt is max(1, $clog2(CLKS_PER_BIT)) bits. Neither may exceed its terminal value.
- Mode changes take effect only at word boundaries. lsb_first is latched per word and never affects a word already in flight.

Test Plan:
1. Reset with rst = 0 mid-stream, then release -> serial_out = IDLE_LEVEL, data_ready = 1, busy = 0, word_done = 0, no bits emitted.
2. WORD_LENGTH = 8, CLKS_PER_BIT = 1; accept 8'h1E with lsb_first = 1 on edge k -> serial_out = 0,1,1,1,1,0,0,0 after edges k+1..k+8; bit_strobe high 8 cycles; word_done high only in the cycle after edge k+8; then IDLE.
3. Same as scenario 2 with lsb_first = 0 -> serial_out = 0,0,0,1,1,1,1,0.
4. Back-to-back: accept 8'h1E (LSB), then 8'hF0 (MSB) two cycles later; hold a third word valid -> data_ready low until the second word enters SHIFT; 16 consecutive bits with no gap; word_done pulses at bits 8 and 16; the third word is accepted right after the reload.
5. CLKS_PER_BIT = 4, accept 8'h01 LSB-first -> serial_out high for 4 cycles then low for 28; bit_strobe every 4th cycle (8 pulses); word_done in cycle 32 only.
6. Reset asserted during bit 3, with a word held in the buffer -> outputs return to reset values immediately; after release, no residual bits and data_ready = 1.
